frame_bank_ctrl: RTL
====================

# frame_bank_ctrl

Ping-pong frame-buffer controller between the Camera Link capture path and the downstream consumers (VGA readout / gravity post-processing). Tracks FVAL/DVAL framing, generates row/column write addresses and per-bank write enables (oWEA = bank A, oWEB = bank B) for the binarized pixel-pair memories, and grants readers exclusive use of the most recently completed frame bank. Guarantees the writer never writes a bank locked by a reader.

## Interface
- ADDR_WIDTH, 11, width of row/column addresses
- ROWS, 480, valid lines per frame
- COLS, 640, valid pixels per line (two per clock)
- FCNT_WIDTH, 16, frame counter width
- CCLK  in  1  capture clock, all logic rising-edge
- RST_N  in  1  asynchronous active-low reset
- iFVAL  in  1  frame valid, active high
- iDVAL  in  1  data valid, one pixel pair per cycle
- iRD_REQ  in  1  reader requests a frame (level, held until grant)
- iRD_DONE  in  1  reader releases its bank (1-cycle pulse)
- oWEA  out  1  write enable, bank A
- oWEB  out  1  write enable, bank B
- oWR_ROW  out  ADDR_WIDTH  write row address
- oWR_COL  out  ADDR_WIDTH  write column address (even values)
- oRD_GRANT  out  1  1-cycle grant pulse
- oRD_BANK  out  1  locked bank (0=A, 1=B), valid from grant until iRD_DONE
- oRD_LOCK  out  1  reader lock held
- oFRAME_CNT  out  FCNT_WIDTH  committed frames, wraps
- oOVR  out  1  sticky overrun: DVAL beyond ROWS/COLS

## Operation
- Edge detect: fval_d/dval_d registers; rise = in & ~d, fall = ~in & d. fval_d resets to 1, so FVAL already high at reset release does not start a frame.
- Writer FSM: W_IDLE -> (FVAL rise) W_FRAME -> (DVAL rise) W_LINE -> (DVAL fall) W_FRAME, row+1 -> (FVAL fall from W_FRAME or W_LINE) W_COMMIT -> W_IDLE.
- Bank choice at FVAL rise: if oRD_LOCK, wr_bank = ~oRD_BANK; else wr_bank = ~last_bank. last_bank resets to B, so the first frame uses A.
- On FVAL rise, if wr_bank == last_bank, rdy is cleared (that frame is being overwritten).
- W_LINE: col starts at 0 on DVAL rise and advances by 2 per DVAL cycle. Write enable = DVAL & row<ROWS & col<COLS, routed to oWEA or oWEB by wr_bank. Out-of-range DVAL sets oOVR and is not written.
- W_COMMIT (1 cycle): last_bank <= wr_bank, rdy <= 1, oFRAME_CNT+1 (wraps). A frame with zero lines still commits.
- Reader FSM: R_IDLE -> (iRD_REQ & rdy) R_LOCK, oRD_GRANT pulse, oRD_BANK <= last_bank -> (iRD_DONE) R_IDLE. iRD_DONE in R_IDLE is ignored. iRD_REQ in R_LOCK is ignored until release.
- Commit and grant in the same cycle: the commit wins. The grant is issued the following cycle with the new last_bank.
- FVAL fall mid-line: treated as line end plus commit.

## Timing
- Reset values: oWEA/oWEB/oRD_GRANT/oRD_LOCK/oOVR = 0; oWR_ROW/oWR_COL/oFRAME_CNT = 0; oRD_BANK = 0; rdy = 0; FSMs idle.
- oWEA/oWEB/oWR_ROW/oWR_COL are registered: 1-cycle latency from the sampled DVAL cycle. The pixel datapath adds one register to align.
- First write of a line: cycle after DVAL rise sample, col = 0.
- oRD_GRANT: asserted the cycle after iRD_REQ is sampled with rdy=1 and reader idle. The earliest grant is 2 cycles after the FVAL fall sample.
- Release: oRD_LOCK drops the cycle after iRD_DONE. A new grant is possible the next cycle.
- Reset mid-frame aborts the frame: no commit, counters cleared, rdy = 0.

## Structure
- Shared package (frame_ctrl_pkg): writer state encoding (W_IDLE, W_FRAME, W_LINE, W_COMMIT), reader states (R_IDLE, R_LOCK), bank constants BANK_A=0 / BANK_B=1.
- Sub-module: val_edge_det, reused for FVAL and DVAL (reset value parameterized: 1 for FVAL, 0 for DVAL).

## Test plan
- Reset with FVAL high, then a full 2-line frame of 4 pairs (ROWS=2, COLS=8) -> no writes until the next FVAL rise. Frame 1: oWEA only, cols 0,2,4,6 on rows 0,1, oFRAME_CNT=1.
- Three back-to-back frames with no reader -> banks A, B, A; oFRAME_CNT=3.
- iRD_REQ after frame 1 (A) is held across frames 2 and 3 -> oRD_BANK=A. Frames 2 and 3 both write B, and oWEA never asserts. iRD_DONE, then next frame -> A.
- iRD_REQ asserted exactly on the W_COMMIT cycle of a B frame -> grant one cycle later with oRD_BANK=B.
- 5 DVAL pairs with COLS=8, and a third line with ROWS=2 -> oOVR=1, no write enable for col 8 or row 2.
- RST_N asserted mid-line -> all outputs at reset values next edge, oFRAME_CNT=0, and iRD_REQ is not granted until a new commit.

Source files
------------

// File: rtl/frame_ctrl_pkg.sv
// Shared encodings for the ping-pong frame-bank controller.
// Writer/reader state machines and bank identifiers.
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FRAME,
        W_LINE,
        W_COMMIT
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_LOCK
    } rd_state_e;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/val_edge_det.sv
// Rise/fall detector for a framing strobe (FVAL or DVAL).
// Reset value is a parameter so a level already high at reset is not a rise.
module val_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= RST_VAL;
        else        sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/frame_bank_ctrl.sv
// Ping-pong frame-buffer controller: write addressing per bank and
// exclusive reader locking of the most recently committed frame.
module frame_bank_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int ROWS       = 480,
    parameter int COLS       = 640,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  CCLK,
    input  logic                  RST_N,
    input  logic                  iFVAL,
    input  logic                  iDVAL,
    input  logic                  iRD_REQ,
    input  logic                  iRD_DONE,
    output logic                  oWEA,
    output logic                  oWEB,
    output logic [ADDR_WIDTH-1:0] oWR_ROW,
    output logic [ADDR_WIDTH-1:0] oWR_COL,
    output logic                  oRD_GRANT,
    output logic                  oRD_BANK,
    output logic                  oRD_LOCK,
    output logic [FCNT_WIDTH-1:0] oFRAME_CNT,
    output logic                  oOVR
);

    localparam logic [ADDR_WIDTH-1:0] ROWS_L = ADDR_WIDTH'(ROWS);
    localparam logic [ADDR_WIDTH-1:0] COLS_L = ADDR_WIDTH'(COLS);

    logic fval_rise, fval_fall, dval_rise, dval_fall;

    wr_state_e wst_q, wst_d;
    rd_state_e rst_q, rst_d;

    logic                  wr_bank_q, wr_bank_d;
    logic                  last_bank_q, last_bank_d;
    logic                  rdy_q, rdy_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                  ovr_q, ovr_d;
    logic                  wea_q, wea_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [ADDR_WIDTH-1:0] wr_col_q, wr_col_d;
    logic                  grant_q, grant_d;
    logic                  rd_bank_q, rd_bank_d;

    logic                  wr_cyc;
    logic                  in_rng;
    logic                  nb;
    logic [ADDR_WIDTH-1:0] cur_col;

    val_edge_det #(.RST_VAL(1'b1)) u_fval (
        .clk    (CCLK),
        .rst_n  (RST_N),
        .sig_i  (iFVAL),
        .rise_o (fval_rise),
        .fall_o (fval_fall)
    );

    val_edge_det #(.RST_VAL(1'b0)) u_dval (
        .clk    (CCLK),
        .rst_n  (RST_N),
        .sig_i  (iDVAL),
        .rise_o (dval_rise),
        .fall_o (dval_fall)
    );

    always_comb begin
        wst_d       = wst_q;
        wr_bank_d   = wr_bank_q;
        last_bank_d = last_bank_q;
        rdy_d       = rdy_q;
        row_d       = row_q;
        col_d       = col_q;
        fcnt_d      = fcnt_q;
        ovr_d       = ovr_q;
        wea_d       = 1'b0;
        web_d       = 1'b0;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        wr_cyc      = 1'b0;
        in_rng      = 1'b0;
        cur_col     = col_q;
        nb          = ~last_bank_q;

        unique case (wst_q)
            W_IDLE: begin
                if (fval_rise) begin
                    nb = (rst_q == R_LOCK) ? ~rd_bank_q : ~last_bank_q;
                    wst_d     = W_FRAME;
                    wr_bank_d = nb;
                    row_d     = '0;
                    col_d     = '0;
                    if (nb == last_bank_q) rdy_d = 1'b0;
                end
            end
            W_FRAME: begin
                if (fval_fall) begin
                    wst_d = W_COMMIT;
                end else if (dval_rise) begin
                    wst_d   = W_LINE;
                    wr_cyc  = 1'b1;
                    cur_col = '0;
                end
            end
            W_LINE: begin
                wr_cyc = iDVAL;
                if (fval_fall) begin
                    wst_d = W_COMMIT;
                end else if (dval_fall) begin
                    wst_d = W_FRAME;
                    if (row_q < ROWS_L) row_d = row_q + ADDR_WIDTH'(1);
                end
            end
            W_COMMIT: begin
                wst_d       = W_IDLE;
                last_bank_d = wr_bank_q;
                rdy_d       = 1'b1;
                fcnt_d      = fcnt_q + FCNT_WIDTH'(1);
            end
            default: wst_d = W_IDLE;
        endcase

        // Column saturates at COLS so a long line can never wrap back in range.
        if (wr_cyc) begin
            in_rng   = (row_q < ROWS_L) && (cur_col < COLS_L);
            wea_d    = in_rng && (wr_bank_q == BANK_A);
            web_d    = in_rng && (wr_bank_q == BANK_B);
            wr_row_d = row_q;
            wr_col_d = cur_col;
            if (cur_col < COLS_L) col_d = cur_col + ADDR_WIDTH'(2);
            if (!in_rng) ovr_d = 1'b1;
        end
    end

    always_comb begin
        rst_d     = rst_q;
        grant_d   = 1'b0;
        rd_bank_d = rd_bank_q;

        unique case (rst_q)
            R_IDLE: begin
                if (iRD_REQ && rdy_q && (wst_q != W_COMMIT)) begin
                    rst_d     = R_LOCK;
                    grant_d   = 1'b1;
                    rd_bank_d = last_bank_q;
                end
            end
            R_LOCK: begin
                if (iRD_DONE) rst_d = R_IDLE;
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            wst_q       <= W_IDLE;
            rst_q       <= R_IDLE;
            wr_bank_q   <= BANK_A;
            last_bank_q <= BANK_B;
            rdy_q       <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            fcnt_q      <= '0;
            ovr_q       <= 1'b0;
            wea_q       <= 1'b0;
            web_q       <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            grant_q     <= 1'b0;
            rd_bank_q   <= BANK_A;
        end else begin
            wst_q       <= wst_d;
            rst_q       <= rst_d;
            wr_bank_q   <= wr_bank_d;
            last_bank_q <= last_bank_d;
            rdy_q       <= rdy_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fcnt_q      <= fcnt_d;
            ovr_q       <= ovr_d;
            wea_q       <= wea_d;
            web_q       <= web_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            grant_q     <= grant_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    assign oWEA       = wea_q;
    assign oWEB       = web_q;
    assign oWR_ROW    = wr_row_q;
    assign oWR_COL    = wr_col_q;
    assign oRD_GRANT  = grant_q;
    assign oRD_BANK   = rd_bank_q;
    assign oRD_LOCK   = (rst_q == R_LOCK);
    assign oFRAME_CNT = fcnt_q;
    assign oOVR       = ovr_q;

endmodule
